// File: rtl/sr_bank_arbiter.sv
// Round-robin arbitrated SR flag bank: one command per 3 cycles (IDLE->APPLY->ACK).
// Requesters hold req_valid until their one-cycle req_ack; there is no other backpressure.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_s,
  input  logic [NREQ*NBITS-1:0] req_r,
  input  logic                  clr_all,
  output logic [NREQ-1:0]       req_ack,
  output logic [NBITS-1:0]      q,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  conflict,
  output logic [NBITS-1:0]      conflict_mask
);

  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             any_vld;
  logic [IDW:0]     cand;
  logic [NBITS-1:0] s_sel, r_sel;
  logic [NBITS-1:0] s_cap, r_cap;
  logic [NBITS-1:0] q_applied;
  logic [NREQ-1:0]  ack_onehot;

  // Search ptr+1, ptr+2, ... modulo NREQ; the first valid requester wins.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!any_vld && req_valid[cand[IDW-1:0]]) begin
        any_vld = 1'b1;
        win     = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    s_sel = '0;
    r_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        s_sel = req_s[i*NBITS +: NBITS];
        r_sel = req_r[i*NBITS +: NBITS];
      end
    end
  end

  always_comb begin
    ack_onehot           = '0;
    ack_onehot[grant_id] = 1'b1;
  end

  // S&R bits fall into neither term, so they keep their old value.
  assign q_applied = (q & ~(r_cap & ~s_cap)) | (s_cap & ~r_cap);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clr_all && any_vld) state_nxt = APPLY;
      APPLY:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q             <= '0;
      req_ack       <= '0;
      grant_id      <= '0;
      conflict      <= 1'b0;
      conflict_mask <= '0;
      ptr           <= IDW'(NREQ-1);
      s_cap         <= '0;
      r_cap         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_all) begin
            q <= '0;
          end else if (any_vld) begin
            s_cap    <= s_sel;
            r_cap    <= r_sel;
            grant_id <= win;
          end
        end
        APPLY: begin
          q             <= q_applied;
          conflict_mask <= s_cap & r_cap;
          conflict      <= |(s_cap & r_cap);
          req_ack       <= ack_onehot;
          ptr           <= grant_id;
        end
        ACK: begin
          req_ack  <= '0;
          conflict <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter with NREQ=4, NBITS=8.
module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_s;
  logic [31:0] req_r;
  logic        clr_all;
  logic [3:0]  req_ack;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  grant_id;
  logic        conflict;
  logic [7:0]  conflict_mask;

  int checks = 0;
  int errors = 0;

  sr_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_s(req_s), .req_r(req_r),
    .clr_all(clr_all), .req_ack(req_ack), .q(q), .busy(busy), .grant_id(grant_id),
    .conflict(conflict), .conflict_mask(conflict_mask)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [7:0] s, input logic [7:0] r);
    req_valid       = 4'(1 << i);
    req_s           = '0;
    req_r           = '0;
    req_s[i*8 +: 8] = s;
    req_r[i*8 +: 8] = r;
  endtask

  // Leaves the bench in the ACK cycle, where ack and new q are visible.
  task automatic run_cmd(input int i, input logic [7:0] s, input logic [7:0] r);
    drive(i, s, r);
    step;
    chk("busy_apply", 32'(busy), 32'd1);
    step;
  endtask

  task automatic end_cmd;
    req_valid = '0;
    req_s     = '0;
    req_r     = '0;
    step;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ack_clear", 32'(req_ack), 32'd0);
  endtask

  initial begin
    int exp_ids[5];
    int n;
    int last;
    exp_ids = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = 4'($urandom);
    req_s     = $urandom;
    req_r     = $urandom;
    clr_all   = 1'($urandom);
    repeat (3) step;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_ack", 32'(req_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_conflict", 32'(conflict), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_mask", 32'(conflict_mask), 32'h0);

    req_valid = '0;
    req_s     = '0;
    req_r     = '0;
    clr_all   = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    chk("idle_busy", 32'(busy), 32'd0);

    // Single command from requester 1, then a partial clear.
    drive(1, 8'h0F, 8'h00);
    step;
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_grant", 32'(grant_id), 32'd1);
    chk("s1_q_early", 32'(q), 32'h00);
    step;
    chk("s1_ack", 32'(req_ack), 32'b0010);
    chk("s1_q", 32'(q), 32'h0F);
    chk("s1_busy2", 32'(busy), 32'd1);
    chk("s1_conflict", 32'(conflict), 32'd0);
    end_cmd;

    run_cmd(1, 8'h00, 8'h03);
    chk("s2_q", 32'(q), 32'h0C);
    chk("s2_ack", 32'(req_ack), 32'b0010);
    end_cmd;

    // Conflict handling.
    run_cmd(2, 8'hF0, 8'h0F);
    chk("c0_q", 32'(q), 32'hF0);
    chk("c0_mask", 32'(conflict_mask), 32'h00);
    end_cmd;

    run_cmd(3, 8'h81, 8'h81);
    chk("c1_q", 32'(q), 32'hF0);
    chk("c1_conflict", 32'(conflict), 32'd1);
    chk("c1_mask", 32'(conflict_mask), 32'h81);
    chk("c1_ack", 32'(req_ack), 32'b1000);
    end_cmd;
    chk("c1_conflict_off", 32'(conflict), 32'd0);

    run_cmd(0, 8'h8F, 8'h81);
    chk("c2_q", 32'(q), 32'hFE);
    chk("c2_conflict", 32'(conflict), 32'd1);
    chk("c2_mask", 32'(conflict_mask), 32'h81);
    end_cmd;
    chk("c2_conflict_off", 32'(conflict), 32'd0);
    chk("c2_mask_hold", 32'(conflict_mask), 32'h81);

    // clr_all beats a simultaneous request.
    run_cmd(1, 8'hFF, 8'h00);
    chk("cl_q_ff", 32'(q), 32'hFF);
    end_cmd;
    clr_all = 1'b1;
    drive(0, 8'h11, 8'h00);
    step;
    chk("cl_q", 32'(q), 32'h00);
    chk("cl_busy", 32'(busy), 32'd0);
    chk("cl_ack", 32'(req_ack), 32'd0);
    clr_all = 1'b0;
    step;
    chk("cl_grant_busy", 32'(busy), 32'd1);
    chk("cl_grant", 32'(grant_id), 32'd0);
    step;
    chk("cl_ack0", 32'(req_ack), 32'b0001);
    chk("cl_q11", 32'(q), 32'h11);
    end_cmd;

    // Reset while in APPLY abandons the command.
    drive(2, 8'hAA, 8'h00);
    step;
    chk("mr_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_q", 32'(q), 32'h00);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_ack", 32'(req_ack), 32'd0);
    req_valid = 4'hF;
    req_s     = '0;
    req_r     = '0;
    step;
    chk("mr_ack_hold", 32'(req_ack), 32'd0);
    chk("mr_q_hold", 32'(q), 32'h00);
    rst_n = 1'b1;

    // All requesters continuously valid: grants rotate from requester 0.
    n    = 0;
    last = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      step;
      if (req_ack != 4'b0) begin
        chk("fair_ack", 32'(req_ack), 32'(1 << exp_ids[n]));
        chk("fair_grant", 32'(grant_id), 32'(exp_ids[n]));
        if (n > 0) chk("fair_gap", 32'(c - last), 32'd3);
        last = c;
        n++;
      end
    end
    chk("fair_count", 32'(n), 32'd5);

    req_valid = '0;
    step;
    step;
    chk("end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Owns a bank of NBITS set/reset storage bits and shares write access among NREQ requesters.
- Each requester submits set (S) and reset (R) vectors. A round-robin arbiter grants one command at a time.
- The granted command is applied to the bank with SR semantics: S=1 sets, R=1 clears, S=R=1 is illegal and holds the bit.
- Provides a clocked, arbitrated replacement for free-running SR latches wherever several agents drive the same flags.

Parameters:
- NREQ, 4, number of requesters (>=2)
- NBITS, 8, width of the SR bank
- IDW, $clog2(NREQ), width of grant_id (derived; not overridden)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- req_valid  input  NREQ  per-requester command valid; held until matching ack
- req_s  input  NREQ*NBITS  set vectors; requester i occupies bits [i*NBITS +: NBITS]
- req_r  input  NREQ*NBITS  reset vectors; same packing as req_s
- clr_all  input  1  synchronous clear of whole bank; sampled in IDLE only
- req_ack  output  NREQ  one-hot, one-cycle completion pulse to the winner
- q  output  NBITS  current bank contents
- busy  output  1  high whenever FSM is not in IDLE
- grant_id  output  IDW  index of the current or last winner
- conflict  output  1  one-cycle pulse when the applied command had any S&R bit
- conflict_mask  output  NBITS  bits that had S&R=1 in the last applied command; held until next apply

Behaviour:
- Reset (async, rst_n=0):
  - q=0, req_ack=0, busy=0, grant_id=0, conflict=0, conflict_mask=0.
  - FSM=IDLE; round-robin pointer ptr=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, APPLY, ACK. Each command takes exactly 3 cycles; throughput is 1 command per 3 cycles.
- IDLE:
  - If clr_all=1: q<=0 at the next edge; stay IDLE; requests are not granted that cycle. clr_all beats requests.
  - Else if any req_valid: pick the first valid index searching ptr+1, ptr+2, ... modulo NREQ.
    - Capture its S and R vectors into internal registers.
    - grant_id<=winner; busy<=1; go to APPLY.
  - Else stay IDLE.
- APPLY (one cycle):
  - At the edge: q <= (q & ~(R & ~S)) | (S & ~R). Bits with S&R=1 keep their old value.
  - conflict_mask <= S & R; conflict <= |(S & R) for one cycle.
  - req_ack[grant_id]<=1; ptr<=grant_id; go to ACK.
- ACK (one cycle):
  - req_ack is high for this cycle only; the requester drops valid.
  - conflict clears at the next edge; req_ack<=0; busy<=0; go to IDLE.
  - req_valid is not sampled in ACK.
- Visibility: new q, req_ack and conflict all become visible together in the cycle after the APPLY edge.
- Captured data: S and R are latched in IDLE. Changing or dropping req_valid, req_s or req_r during APPLY/ACK has no effect; the captured command still completes and is acked.
- A requester holding valid after its ack is treated as a new request. With others waiting, it is serviced only after them because of round-robin.
- Simultaneous requests: exactly one winner per arbitration. With all NREQ requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- clr_all asserted during APPLY/ACK is ignored; the driver holds it until busy=0.
- Reset mid-operation: the command is abandoned, no ack is issued, and q returns to 0.

Test Plan:
- Reset: hold rst_n=0, drive random inputs -> q=0, req_ack=0, busy=0, conflict=0. Release rst_n -> FSM in IDLE, busy=0.
- Single command: req_valid=4'b0010, req1 S=8'h0F, R=0 -> busy high 2 cycles, req_ack=4'b0010 one cycle, q=8'h0F. Follow with R=8'h03, S=0 -> q=8'h0C.
- Fairness: req_valid=4'b1111 held, ack each grant -> grant_id sequence 0,1,2,3,0; req_ack always one-hot; acks exactly 3 cycles apart.
- Conflict: q=8'hF0, command S=8'h81, R=8'h81 -> q stays 8'hF0. Then q=8'hF0 with S=8'h8F, R=8'h81 -> q=8'hFE, conflict one-cycle pulse, conflict_mask=8'h81.
- clr_all priority: q=8'hFF, clr_all=1 and req_valid=4'b0001 together in IDLE -> q=8'h00 next cycle, no ack. Request is granted on the following IDLE cycle once clr_all=0.
- Reset mid-op: assert rst_n=0 while in APPLY -> no req_ack, q=0, busy=0. After release, a pending request is re-arbitrated starting from requester 0.
